// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and constants for the E-stage M-extension unit:
//             controller state encoding, funct3 operation codes, widths.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // Counter value during the final (32nd) iteration
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_datapath
//  Purpose  : One iteration of unsigned shift-add multiply or restoring
//             shift-subtract divide on a 64-bit accumulator.
//             Multiply : acc = {partial_hi, multiplier}, operand = multiplicand
//             Divide   : acc = {remainder, dividend/quotient}, operand = divisor
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic                i_is_div,
    input  logic [XLEN-1:0]     i_operand,
    input  logic [2*XLEN-1:0]   i_acc,
    output logic [2*XLEN-1:0]   o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_fits;
    logic [XLEN-1:0] w_sub;

    // Single-step next accumulator value for either operation
    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, carry kept
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
        // Divide: shift the next dividend bit into the partial remainder
        w_rem_sh = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_fits   = (w_rem_sh >= {1'b0, i_operand});
        // When the trial subtraction succeeds the difference is below 2^32,
        // so modular 32-bit subtraction is exact
        w_sub    = w_rem_sh[XLEN-1:0] - i_operand;
        o_acc    = i_acc;
        if (i_is_div) begin
            if (w_fits) begin
                o_acc = {w_sub, i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc = {w_sum, i_acc[XLEN-1:1]};
            end else begin
                o_acc = {1'b0, i_acc[2*XLEN-1:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_execute_muldiv
//  Purpose  : Iterative E-stage multiply/divide unit. Stalls the front of the
//             pipeline for 32 iterations, then presents a registered result
//             with a one-cycle done strobe. Divide-by-zero and signed
//             overflow resolve in a single cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_execute_muldiv
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            async_reset,
    input  logic            sync_reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_operand;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] w_acc_next;
    logic              r_neg_main;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_quick;
    logic [XLEN-1:0]   w_quick_result;
    logic              w_last_iter;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    muldiv_datapath u_datapath (
        .i_is_div  (r_state == ST_DIV),
        .i_operand (r_operand),
        .i_acc     (r_acc),
        .o_acc     (w_acc_next)
    );

    // Operand signedness, magnitudes and single-cycle special cases
    always_comb begin
        w_a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        w_b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                     (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_a_neg    = w_a_signed && op_a[XLEN-1];
        w_b_neg    = w_b_signed && op_b[XLEN-1];
        w_abs_a    = w_a_neg ? -op_a : op_a;
        w_abs_b    = w_b_neg ? -op_b : op_b;
        w_div_zero = funct3[2] && (op_b == '0);
        w_div_ovf  = funct3[2] && !funct3[0] &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        w_quick    = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_quick_result = funct3[1] ? op_a : '1;
        end else begin
            // Overflow: quotient is op_a itself (0x80000000), remainder zero
            w_quick_result = funct3[1] ? '0 : op_a;
        end
    end

    // Sign fix-up and result selection from the final iteration's accumulator
    always_comb begin
        w_last_iter = (r_count == ITER_LAST);
        w_prod      = r_neg_main ? -w_acc_next : w_acc_next;
        w_quot      = r_neg_main ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
        w_rem       = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
        if (!r_f3[2]) begin
            w_final = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            w_final = r_f3[1] ? w_rem : w_quot;
        end
    end

    // Controller state register
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next-state logic; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_quick) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = funct3[2] ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_last_iter) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (!sync_reset) begin
            w_state_next = ST_IDLE;
        end
    end

    // Operand capture, iteration counter, accumulator and result register
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            r_count    <= '0;
            r_f3       <= '0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
        end else if (!sync_reset) begin
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_f3       <= funct3;
                        r_count    <= '0;
                        r_neg_main <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        if (funct3[2]) begin
                            r_operand <= w_abs_b;
                            r_acc     <= {{XLEN{1'b0}}, w_abs_a};
                        end else begin
                            r_operand <= w_abs_a;
                            r_acc     <= {{XLEN{1'b0}}, w_abs_b};
                        end
                        if (w_quick) begin
                            r_result <= w_quick_result;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (w_last_iter) begin
                        r_result <= w_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; stall is forced low while in reset
    always_comb begin
        busy      = (r_state == ST_MUL) || (r_state == ST_DIV);
        done      = (r_state == ST_DONE);
        stall_req = async_reset && (((r_state == ST_IDLE) && start) || busy);
        result    = r_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_execute_muldiv
//  Purpose  : Scoreboard bench for pipe_execute_muldiv: directed corner cases,
//             flush/reset aborts and randomized operations against an
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_execute_muldiv;

    logic        clock = 1'b0;
    logic        async_reset;
    logic        sync_reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_edges = 0;
    logic [31:0] last_res = '0;

    pipe_execute_muldiv dut (
        .clock       (clock),
        .async_reset (async_reset),
        .sync_reset  (sync_reset),
        .start       (start),
        .funct3      (funct3),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall_req   (stall_req),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clock = ~clock;

    always @(posedge clock) n_edges <= n_edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edges);
    endtask

    // Reference model: plain integer arithmetic from the RISC-V M rules
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_quick(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: every done strobe must match the oldest expected entry
    always @(negedge clock) begin
        if (async_reset && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_edge", 32'(n_edges), 32'(e.cyc));
            end
        end
    end

    // Issue one operation, check stall/busy timing; poke=1 drives a stray start mid-op
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        int   k;
        bit   q;
        int   stalls;
        bit   seen;
        exp_t e;
        @(negedge clock);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        k = n_edges + 1;
        q = is_quick(f3, a, b);
        e.res = model(f3, a, b);
        e.cyc = q ? k : k + 32;
        sb_q.push_back(e);
        last_res = e.res;
        #1 check("stall_on_start", 32'(stall_req), 32'd1);
        @(posedge clock);
        #1 start = 1'b0;
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (poke && i == 5) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3;
            end
            if (poke && i == 7) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                check("stall_in_done", 32'(stall_req), 32'd0);
                check("busy_in_done", 32'(busy), 32'd0);
            end else if (stall_req) begin
                stalls++;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("stall_cycles", 32'(stalls), q ? 32'd0 : 32'd32);
    endtask

    // Start an operation that will be aborted (no scoreboard entry)
    task automatic kick(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        async_reset = 1'b0; sync_reset = 1'b1; start = 1'b1;
        funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        start = 1'b0;
        async_reset = 1'b1;

        // Directed corner cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul_7_m3_held", result, 32'hFFFF_FFEB);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 1'b0);
        run_op(3'b101, 32'd100, 32'd0, 1'b0);
        run_op(3'b111, 32'd100, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Stray start while busy must be ignored
        run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // Flush at iteration 10: no done, result unchanged
        kick(3'b001, 32'h0BAD_CAFE, 32'h0000_1234);
        repeat (9) @(posedge clock);
        @(negedge clock);
        sync_reset = 1'b0;
        @(negedge clock);
        sync_reset = 1'b1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall_req), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("flush_no_done", 32'(n_done), 32'd0);
        check("flush_result", result, last_res);

        // Async reset mid-divide
        kick(3'b100, 32'd123456, 32'd77);
        repeat (15) @(posedge clock);
        @(negedge clock);
        async_reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        start = 1'b1;
        #1 check("arst_stall_start", 32'(stall_req), 32'd0);
        start = 1'b0;
        @(negedge clock);
        async_reset = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        check("arst_no_restart", 32'(n_done), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, 1'b0);
        check("mul_3_4_held", result, 32'd12);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b0);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
